// File: rtl/serdes_link_ctrl.sv
// Link bring-up and traffic controller for the 8b10b SERDES parallel domain.
// Forces K28.5 until the receiver locks, then muxes user words with comma fill.
`timescale 1ns/1ps

module serdes_link_ctrl #(
  parameter int LOCK_COUNT     = 16,
  parameter int ALIGN_TIMEOUT  = 1024,
  parameter int COMMA_MIN      = 64,
  parameter int ERR_WINDOW     = 256,
  parameter int ERR_THRESH     = 4,
  parameter int COMMA_INTERVAL = 512
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       link_enable,
  input  logic [7:0] tx_user_data,
  input  logic       tx_user_k,
  input  logic       tx_user_valid,
  output logic       tx_user_ready,
  output logic [7:0] tx_data,
  output logic       tx_k,
  input  logic [7:0] rx_data,
  input  logic       rx_k,
  input  logic       rx_valid,
  input  logic       rx_disp_err,
  input  logic       rx_code_err,
  output logic [7:0] rx_user_data,
  output logic       rx_user_k,
  output logic       rx_user_valid,
  output logic       link_up,
  output logic [1:0] link_state,
  output logic [7:0] resync_count
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_TX_COMMA = 2'd1;
  localparam logic [1:0] ST_ALIGN    = 2'd2;
  localparam logic [1:0] ST_UP       = 2'd3;

  localparam logic [7:0] K28_5 = 8'hBC;

  localparam int CYC_W  = $clog2(COMMA_MIN + 1);
  localparam int LOCK_W = $clog2(LOCK_COUNT + 1);
  localparam int TO_W   = $clog2(ALIGN_TIMEOUT + 1);
  localparam int WORD_W = $clog2(COMMA_INTERVAL + 1);
  localparam int WIN_W  = $clog2(ERR_WINDOW + 1);
  localparam int ERR_W  = $clog2(ERR_THRESH + 1);

  logic [1:0]      r_state;
  logic [CYC_W-1:0]  r_cyc_cnt;
  logic [LOCK_W-1:0] r_lock_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic [WORD_W-1:0] r_word_cnt;
  logic [WIN_W-1:0]  r_win_cnt;
  logic [ERR_W-1:0]  r_err_cnt;
  logic [7:0]      r_resync_cnt;
  logic [7:0]      r_tx_data;
  logic            r_tx_k;
  logic [7:0]      r_rx_user_data;
  logic            r_rx_user_k;
  logic            r_rx_user_valid;

  logic       w_is_up;
  logic       w_force_comma;
  logic       w_accept;
  logic       w_rx_err;
  logic       w_rx_comma;
  logic       w_clean_comma;
  logic       w_lock_hit;
  logic       w_align_tmo;
  logic       w_win_end;
  logic       w_err_trip;
  logic       w_deliver;
  logic [1:0] w_state_nxt;
  logic       w_resync_inc;
  logic       w_state_chg;

  assign w_is_up       = (r_state == ST_UP);
  assign w_force_comma = w_is_up && (r_word_cnt == WORD_W'(COMMA_INTERVAL));
  assign tx_user_ready = w_is_up && !w_force_comma;
  assign w_accept      = tx_user_valid && tx_user_ready;

  assign w_rx_err      = rx_disp_err || rx_code_err;
  assign w_rx_comma    = rx_k && (rx_data == K28_5);
  assign w_clean_comma = rx_valid && w_rx_comma && !w_rx_err;
  assign w_lock_hit    = w_clean_comma && (r_lock_cnt == LOCK_W'(LOCK_COUNT - 1));
  assign w_align_tmo   = (r_to_cnt == TO_W'(ALIGN_TIMEOUT - 1));
  assign w_win_end     = (r_win_cnt == WIN_W'(ERR_WINDOW - 1));
  // The error that completes a window is still counted before the window clears.
  assign w_err_trip    = rx_valid && w_rx_err && (r_err_cnt == ERR_W'(ERR_THRESH - 1));
  assign w_deliver     = w_is_up && rx_valid && !w_rx_err && !w_rx_comma;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt  = r_state;
    w_resync_inc = 1'b0;
    if (!link_enable) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:     w_state_nxt = ST_TX_COMMA;
        ST_TX_COMMA: if (r_cyc_cnt == CYC_W'(COMMA_MIN - 1)) w_state_nxt = ST_ALIGN;
        ST_ALIGN: begin
          if (w_lock_hit) begin
            w_state_nxt = ST_UP;
          end else if (w_align_tmo) begin
            w_state_nxt  = ST_TX_COMMA;
            w_resync_inc = 1'b1;
          end
        end
        ST_UP: begin
          if (w_err_trip) begin
            w_state_nxt  = ST_TX_COMMA;
            w_resync_inc = 1'b1;
          end
        end
        default:     w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign w_state_chg = (w_state_nxt != r_state);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cyc_cnt    <= '0;
      r_lock_cnt   <= '0;
      r_to_cnt     <= '0;
      r_word_cnt   <= '0;
      r_win_cnt    <= '0;
      r_err_cnt    <= '0;
      r_resync_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_resync_inc && (r_resync_cnt != 8'hFF)) begin
        r_resync_cnt <= r_resync_cnt + 8'd1;
      end
      // Every transition starts the new state with all phase counters at zero.
      if (w_state_chg) begin
        r_cyc_cnt  <= '0;
        r_lock_cnt <= '0;
        r_to_cnt   <= '0;
        r_word_cnt <= '0;
        r_win_cnt  <= '0;
        r_err_cnt  <= '0;
      end else begin
        case (r_state)
          ST_TX_COMMA: r_cyc_cnt <= r_cyc_cnt + CYC_W'(1);
          ST_ALIGN: begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
            if (rx_valid) begin
              r_lock_cnt <= w_clean_comma ? (r_lock_cnt + LOCK_W'(1)) : '0;
            end
          end
          ST_UP: begin
            if (w_force_comma) begin
              r_word_cnt <= '0;
            end else if (w_accept) begin
              r_word_cnt <= r_word_cnt + WORD_W'(1);
            end
            if (rx_valid) begin
              if (w_win_end) begin
                r_win_cnt <= '0;
                r_err_cnt <= '0;
              end else begin
                r_win_cnt <= r_win_cnt + WIN_W'(1);
                r_err_cnt <= r_err_cnt + ERR_W'(w_rx_err);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Datapath registers; reset leaves the encoder sending K28.5.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_data       <= K28_5;
      r_tx_k          <= 1'b1;
      r_rx_user_data  <= '0;
      r_rx_user_k     <= 1'b0;
      r_rx_user_valid <= 1'b0;
    end else begin
      r_tx_data       <= w_accept ? tx_user_data : K28_5;
      r_tx_k          <= w_accept ? tx_user_k : 1'b1;
      r_rx_user_valid <= w_deliver;
      if (w_deliver) begin
        r_rx_user_data <= rx_data;
        r_rx_user_k    <= rx_k;
      end
    end
  end

  assign tx_data       = r_tx_data;
  assign tx_k          = r_tx_k;
  assign rx_user_data  = r_rx_user_data;
  assign rx_user_k     = r_rx_user_k;
  assign rx_user_valid = r_rx_user_valid;
  assign link_up       = w_is_up;
  assign link_state    = r_state;
  assign resync_count  = r_resync_cnt;

endmodule
